bcd_seq_conv: RTL and testbench
===============================

Name: bcd_seq_conv

Overview:
- Multi-cycle, parametrised binary-to-BCD converter using shift-add-3 (double dabble), one input bit per clock.
- Replaces the flat combinational converter wherever BIN_W grows beyond 8 bits or timing closure matters, for example display drivers and UART decimal print paths.
- Uses valid/ready handshakes on both sides so it can sit between a producer and a display or serialiser.

Parameters:
- BIN_W, 8, width of the binary input (>= 2).
- DIGITS, 3, number of BCD output digits. May be fewer than needed for BIN_W; see ovf.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  converter can accept a word.
- in_bin  in  BIN_W  binary value, sampled on the input handshake.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts the result.
- out_bcd  out  4*DIGITS  packed BCD. Digit 0 (ones) is [3:0]; digit k is [4k+3:4k].
- out_ovf  out  1  value did not fit in DIGITS digits.
- out_neg  out  1  sign flag. Driven only with BCD_SIGNED_EN; otherwise constant 0.

Behaviour:
- Reset: on a clk edge with rst_n=0, state=IDLE. in_ready=1, out_valid=0, out_bcd=0, out_ovf=0, out_neg=0, bit counter=0. Reset overrides everything, including mid-conversion and a pending output; the in-flight word is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_bin into the shift register, clear the BCD accumulator and ovf, load counter=BIN_W-1, then go to SHIFT.
  - SHIFT: in_ready=0. Each cycle:
    - Every digit >= 5 gets +3, all digits in parallel.
    - The whole {digits, shift_reg} chain then shifts left by 1. The MSB of shift_reg enters digit 0.
    - If the MSB of the top digit is 1 before the shift, set ovf (sticky).
    - When counter==0, go to DONE; otherwise decrement the counter.
  - DONE: out_valid=1; out_bcd, out_ovf and out_neg are stable. On out_valid&out_ready, go to IDLE. in_ready stays 0 in DONE, so no same-cycle re-accept.
- Latency: the input handshake occurs on edge E. out_valid rises after edge E+BIN_W, i.e. BIN_W cycles in SHIFT. Minimum throughput is one word per BIN_W+2 cycles.
- Width rules:
  - Digit adjust is 4-bit. The carry out of the top digit feeds only ovf.
  - With ovf=1, out_bcd holds the value mod 10^DIGITS.
  - With ovf=0, out_bcd equals the exact decimal value.
- in_valid during SHIFT/DONE is ignored (in_ready=0); the producer holds its data.
- Holding out_ready=0 holds the outputs indefinitely with no change.

Optional Feature:
- Macro BCD_SIGNED_EN.
- Defined:
  - in_bin is treated as two's complement.
  - On accept, out_neg latches in_bin[BIN_W-1]. The shift register loads |in_bin| as a BIN_W-bit unsigned value, so -2^(BIN_W-1) converts correctly.
  - Latency is unchanged.
- Undefined:
  - in_bin is unsigned and out_neg is tied to 0.
  - No negate logic is present.

Decomposition:
- Package bcd_pkg:
  - state encoding constants ST_IDLE/ST_SHIFT/ST_DONE.
  - constant function min_digits(w) = ceil(w*log10(2)), used by benches to pick DIGITS.
  - digit width constant 4.
- Sub-module bcd_digit_adj: combinational 4-bit "if >=5 add 3", generate-instantiated DIGITS times inside bcd_seq_conv.

Test Plan:
- BIN_W=8, DIGITS=3, in_bin=255, out_ready=1 -> out_valid exactly 8 cycles after accept; out_bcd=12'h255, ovf=0. Then in_bin=0 -> 12'h000. Then in_bin=100 -> 12'h100.
- Backpressure: convert 37 with out_ready=0 for 20 cycles -> out_bcd=12'h037 stable, in_ready=0 throughout. Raise out_ready -> IDLE next cycle, in_ready=1.
- Overflow: BIN_W=8, DIGITS=2, in_bin=255 -> out_bcd=8'h55, out_ovf=1. in_bin=99 -> 8'h99, ovf=0.
- Reset mid-op: assert rst_n=0 at SHIFT cycle 4 of converting 200 -> next edge: out_valid=0, in_ready=1, out_bcd=0. A following conversion of 42 -> 12'h042.
- Wide: BIN_W=16, DIGITS=5, in_bin=65535 -> 20'h65535 after 16 cycles. Back-to-back in_valid held high -> accepts spaced exactly BIN_W+2 cycles apart.
- BCD_SIGNED_EN, BIN_W=8, DIGITS=3: in_bin=8'h80 -> neg=1, 12'h128. 8'hFF -> neg=1, 12'h001. 8'h7F -> neg=0, 12'h127.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: state encoding,
// digit width and a helper that sizes DIGITS for a given binary width.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ceil(w * log10(2)) using a fixed-point approximation of log10(2) = 0.30103
    function automatic int min_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decade.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    assign adjusted = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bcd_seq_conv.sv
// Multi-cycle binary-to-BCD converter (shift-add-3, one input bit per clock) with
// valid/ready on both sides. Define BCD_SIGNED_EN to convert two's-complement input.
module bcd_seq_conv
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIN_W-1:0]          in_bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                      out_ovf,
    output logic                      out_neg
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_t             state_reg;
    logic [BIN_W-1:0]   shift_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_reg;
    logic               ovf_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [BIN_W-1:0]   load_bin;

    // All digits are corrected in parallel before each shift
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (bcd_reg[gi*DIGIT_W +: DIGIT_W]),
                .adjusted (bcd_adj[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

`ifdef BCD_SIGNED_EN
    logic neg_reg;

    // Magnitude as BIN_W-bit unsigned, so the most negative value maps to 2^(BIN_W-1)
    assign load_bin = in_bin[BIN_W-1] ? ((~in_bin) + BIN_W'(1)) : in_bin;
    assign out_neg  = neg_reg;
`else
    assign load_bin = in_bin;
    assign out_neg  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            shift_reg     <= '0;
            bcd_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
`ifdef BCD_SIGNED_EN
            neg_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        shift_reg    <= load_bin;
                        bcd_reg      <= '0;
                        ovf_reg      <= 1'b0;
                        cnt_reg      <= CNT_W'(BIN_W - 1);
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_SHIFT;
`ifdef BCD_SIGNED_EN
                        neg_reg      <= in_bin[BIN_W-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    bcd_reg   <= {bcd_adj[BCD_W-2:0], shift_reg[BIN_W-1]};
                    shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
                    // A set top bit would be shifted out of the accumulator: value too large
                    if (bcd_adj[BCD_W-1]) begin
                        ovf_reg <= 1'b1;
                    end
                    if (cnt_reg == '0) begin
                        state_reg     <= ST_DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_bcd   = bcd_reg;
    assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed bench for bcd_seq_conv: three instances (8/3, 8/2 for overflow, 16/5 wide)
// checked against hand-computed BCD values, latencies and handshake spacing.
module tb_bcd_seq_conv;
    import bcd_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: BIN_W=8, DIGITS=3
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf, a_out_neg;
    logic [7:0]  a_in_bin;
    logic [11:0] a_out_bcd;
    // Instance B: BIN_W=8, DIGITS=2 (overflow)
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_out_neg;
    logic [7:0]  b_in_bin;
    logic [7:0]  b_out_bcd;
    // Instance C: BIN_W=16, DIGITS=min_digits(16)=5
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf, c_out_neg;
    logic [15:0] c_in_bin;
    logic [19:0] c_out_bcd;

    bcd_seq_conv #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_bin(a_in_bin), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_bcd(a_out_bcd), .out_ovf(a_out_ovf), .out_neg(a_out_neg)
    );
    bcd_seq_conv #(.BIN_W(8), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_bin(b_in_bin), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bcd(b_out_bcd), .out_ovf(b_out_ovf), .out_neg(b_out_neg)
    );
    bcd_seq_conv #(.BIN_W(16), .DIGITS(min_digits(16))) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_bin(c_in_bin), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_bcd(c_out_bcd), .out_ovf(c_out_ovf), .out_neg(c_out_neg)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic g_ready(input int sel);
        case (sel)
            0:       return a_in_ready;
            1:       return b_in_ready;
            default: return c_in_ready;
        endcase
    endfunction

    function automatic logic g_valid(input int sel);
        case (sel)
            0:       return a_out_valid;
            1:       return b_out_valid;
            default: return c_out_valid;
        endcase
    endfunction

    function automatic logic [19:0] g_bcd(input int sel);
        case (sel)
            0:       return {8'h00, a_out_bcd};
            1:       return {12'h000, b_out_bcd};
            default: return c_out_bcd;
        endcase
    endfunction

    function automatic logic g_ovf(input int sel);
        case (sel)
            0:       return a_out_ovf;
            1:       return b_out_ovf;
            default: return c_out_ovf;
        endcase
    endfunction

    function automatic logic g_neg(input int sel);
        case (sel)
            0:       return a_out_neg;
            1:       return b_out_neg;
            default: return c_out_neg;
        endcase
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [15:0] d);
        case (sel)
            0:       begin a_in_valid = v; a_in_bin = d[7:0]; end
            1:       begin b_in_valid = v; b_in_bin = d[7:0]; end
            default: begin c_in_valid = v; c_in_bin = d;      end
        endcase
    endtask

    // Returns just after the accepting edge (edge E + 1 time unit)
    task automatic start(input int sel, input logic [15:0] d, output bit ok);
        logic rdy;
        ok = 1'b0;
        set_in(sel, 1'b1, d);
        for (int i = 0; i < 40; i++) begin
            rdy = g_ready(sel);
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        set_in(sel, 1'b0, d);
        chk("accept", ok, 1'b1);
    endtask

    task automatic wait_valid(input int sel, input int budget, output int lat);
        lat = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (g_valid(sel)) break;
        end
    endtask

    task automatic conv(input int sel, input logic [15:0] d, input int exp_lat,
                        input logic [19:0] exp_bcd, input logic exp_ovf, input logic exp_neg,
                        input string tag);
        bit ok;
        int lat;
        start(sel, d, ok);
        wait_valid(sel, exp_lat + 10, lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_valid"}, g_valid(sel), 1'b1);
        chk({tag, "_bcd"}, g_bcd(sel), exp_bcd);
        chk({tag, "_ovf"}, g_ovf(sel), exp_ovf);
        chk({tag, "_neg"}, g_neg(sel), exp_neg);
        $display("xact %s inst=%0d in=%0d bcd=%h ovf=%b neg=%b lat=%0d",
                 tag, sel, d, g_bcd(sel), g_ovf(sel), g_neg(sel), lat);
        // out_ready is high here, so the result is consumed on the next edge
        @(posedge clk);
        #1;
        chk({tag, "_idle_rdy"}, g_ready(sel), 1'b1);
        chk({tag, "_idle_vld"}, g_valid(sel), 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lat;
        int n, na;
        int acc [3];
        logic rdy;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_bin = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_bin = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_bin = '0; c_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_bcd", a_out_bcd, 12'h000);
        chk("rst_out_ovf", a_out_ovf, 1'b0);
        chk("rst_out_neg", a_out_neg, 1'b0);
        chk("min_digits16", min_digits(16), 5);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic conversions on 8/3
        conv(0, 16'd255, 8, 20'h00255, 1'b0, 1'b0, "a255");
        conv(0, 16'd0,   8, 20'h00000, 1'b0, 1'b0, "a0");
        conv(0, 16'd100, 8, 20'h00100, 1'b0, 1'b0, "a100");

        // Backpressure: result must sit unchanged while out_ready is low
        a_out_ready = 1'b0;
        start(0, 16'd37, ok);
        wait_valid(0, 20, lat);
        chk("bp_lat", lat, 8);
        for (int i = 0; i < 20; i++) begin
            chk("bp_bcd", a_out_bcd, 12'h037);
            chk("bp_valid", a_out_valid, 1'b1);
            chk("bp_in_ready", a_in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        $display("xact bp inst=0 in=37 bcd=%h held 20 cycles", a_out_bcd);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_vld", a_out_valid, 1'b0);
        chk("bp_release_rdy", a_in_ready, 1'b1);

        // Overflow on 8/2
        conv(1, 16'd255, 8, 20'h00055, 1'b1, 1'b0, "b255");
        conv(1, 16'd99,  8, 20'h00099, 1'b0, 1'b0, "b99");

        // Reset during SHIFT cycle 4 of converting 200
        start(0, 16'd200, ok);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", a_in_ready, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_vld", a_out_valid, 1'b0);
        chk("mid_rst_rdy", a_in_ready, 1'b1);
        chk("mid_rst_bcd", a_out_bcd, 12'h000);
        $display("xact midrst inst=0 in=200 aborted bcd=%h", a_out_bcd);
        rst_n = 1'b1;
        conv(0, 16'd42, 8, 20'h00042, 1'b0, 1'b0, "a42");

        // Wide 16/5
        conv(2, 16'd65535, 16, 20'h65535, 1'b0, 1'b0, "c65535");

        // Back-to-back with in_valid held high: accepts every BIN_W+2 cycles
        c_in_valid = 1'b1;
        c_in_bin   = 16'd1234;
        n  = 0;
        na = 0;
        for (int i = 0; i < 80 && na < 3; i++) begin
            rdy = c_in_ready;
            @(posedge clk);
            #1;
            n++;
            if (rdy) begin
                acc[na] = n;
                na++;
            end
        end
        c_in_valid = 1'b0;
        chk("b2b_count", na, 3);
        chk("b2b_gap1", acc[1] - acc[0], 18);
        chk("b2b_gap2", acc[2] - acc[1], 18);
        wait_valid(2, 30, lat);
        chk("b2b_lat", lat, 16);
        chk("b2b_bcd", c_out_bcd, 20'h01234);
        $display("xact b2b inst=2 in=1234 accepts=%0d,%0d,%0d bcd=%h",
                 acc[0], acc[1], acc[2], c_out_bcd);
        @(posedge clk);
        #1;

        // Sign handling
`ifdef BCD_SIGNED_EN
        conv(0, 16'h0080, 8, 20'h00128, 1'b0, 1'b1, "s80");
        conv(0, 16'h00FF, 8, 20'h00001, 1'b0, 1'b1, "sFF");
        conv(0, 16'h007F, 8, 20'h00127, 1'b0, 1'b0, "s7F");
`else
        conv(0, 16'h0080, 8, 20'h00128, 1'b0, 1'b0, "u80");
        conv(0, 16'h00FF, 8, 20'h00255, 1'b0, 1'b0, "uFF");
        conv(0, 16'h007F, 8, 20'h00127, 1'b0, 1'b0, "u7F");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
